// File: rtl/fir_tdm_decim.sv
// -----------------------------------------------------------------------------
// fir_tdm_decim
//
// Time-multiplexed FIR filter with decimation. One signed multiplier/accumulator
// walks the TAPS coefficients once per output, so an output costs TAPS+2 clocks.
// It sits between the mic/CIC front end and the downstream audio stages.
//
// Coefficients can be loaded at run time and reset to an impulse
// (coef[0] = 1 << OUT_SHIFT), so after reset the output equals the input.
//
// Ports
//   clk          : clock
//   rst_n        : asynchronous reset, active-low
//   sample_in    : signed input sample (DATA_WIDTH)
//   sample_valid : sample_in is valid
//   sample_ready : block accepts a sample this cycle (high only in IDLE)
//   coef_we      : coefficient write strobe (honoured only in IDLE)
//   coef_addr    : coefficient index; indices >= TAPS are ignored
//   coef_data    : signed coefficient value (COEF_WIDTH)
//   coef_ack     : one-cycle pulse, the write was applied
//   out          : signed filter output (OUT_WIDTH), held between updates
//   out_valid    : one-cycle pulse, out is new
//   out_sat      : out was clamped on this update (qualified by out_valid)
//
// Build option
//   FIR_SAT_EN   : when defined, the scaled result is clamped to the OUT_WIDTH
//                  signed range and out_sat flags the clamp. When undefined,
//                  the low OUT_WIDTH bits are kept (two's-complement wrap) and
//                  out_sat stays 0.
// -----------------------------------------------------------------------------
module fir_tdm_decim #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 30,
    parameter int DECIM      = 1,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         coef_we,
    input  logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         coef_ack,
    output logic signed [OUT_WIDTH-1:0]  out,
    output logic                         out_valid,
    output logic                         out_sat
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int FILL_W = $clog2(TAPS + 1);
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    // log2(TAPS) guard bits: a sum of TAPS full-scale products cannot overflow.
    localparam int ACC_W  = PROD_W + $clog2(TAPS);

    localparam logic [PTR_W-1:0]  LAST_TAP_C = PTR_W'(TAPS - 1);
    localparam logic [PTR_W:0]    TAPS_EXT_C = (PTR_W + 1)'(TAPS);
    localparam logic [FILL_W-1:0] FILL_MAX_C = FILL_W'(TAPS);
    localparam logic [DCNT_W-1:0] DCNT_END_C = DCNT_W'(DECIM - 1);
    localparam logic signed [COEF_WIDTH-1:0] COEF_RST0_C = COEF_WIDTH'(1'b1) << OUT_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic signed [DATA_WIDTH-1:0] dline_r [TAPS];
    logic signed [COEF_WIDTH-1:0] coef_r  [TAPS];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  k_r;
    logic [FILL_W-1:0] fill_r;
    logic [DCNT_W-1:0] dcnt_r;
    logic signed [ACC_W-1:0] acc_r;

    logic                        coef_ack_r;
    logic                        sample_ready_r;
    logic signed [OUT_WIDTH-1:0] out_r;
    logic                        out_valid_r;
    logic                        out_sat_r;

    logic in_idle_s;
    logic accept_s;
    logic dec_hit_s;
    logic mac_start_s;
    logic mac_last_s;
    logic addr_ok_s;
    logic coef_wr_s;
    logic fill_full_s;
    logic emit_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_sum_s;
    // {clamp flag, formatted output}
    logic [OUT_WIDTH:0]       fmt_s;

    assign in_idle_s   = (state_r == ST_IDLE);
    assign accept_s    = in_idle_s && sample_valid;
    assign dec_hit_s   = (dcnt_r == DCNT_END_C);
    assign mac_start_s = accept_s && dec_hit_s;
    assign mac_last_s  = (state_r == ST_MAC) && (k_r == LAST_TAP_C);
    assign addr_ok_s   = ({1'b0, coef_addr} < TAPS_EXT_C);
    assign coef_wr_s   = in_idle_s && coef_we && addr_ok_s;
    assign fill_full_s = (fill_r == FILL_MAX_C);
    // Results produced during warm-up are discarded and leave out unchanged.
    assign emit_s      = mac_last_s && fill_full_s;

    // rd_ptr_r walks backwards from the newest sample while k_r walks the coefficients forward.
    assign prod_s    = PROD_W'(dline_r[rd_ptr_r]) * PROD_W'(coef_r[k_r]);
    assign acc_sum_s = acc_r + ACC_W'(prod_s);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX_C = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN_C = ACC_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    // Clamp a scaled accumulator to the output range; MSB of the result is the clamp flag.
    function automatic logic [OUT_WIDTH:0] sat_fmt(input logic signed [ACC_W-1:0] v);
        logic [OUT_WIDTH:0] r;
        if (v > OUT_MAX_C) begin
            r = {1'b1, OUT_MAX_C[OUT_WIDTH-1:0]};
        end else if (v < OUT_MIN_C) begin
            r = {1'b1, OUT_MIN_C[OUT_WIDTH-1:0]};
        end else begin
            r = {1'b0, v[OUT_WIDTH-1:0]};
        end
        return r;
    endfunction

    logic signed [ACC_W-1:0] scaled_s;
    // Arithmetic shift: truncates toward -inf.
    assign scaled_s = acc_sum_s >>> OUT_SHIFT;
    assign fmt_s    = sat_fmt(scaled_s);
`else
    // Keep the low bits of the arithmetically shifted sum; overflow wraps.
    assign fmt_s = {1'b0, OUT_WIDTH'(acc_sum_s >>> OUT_SHIFT)};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mac_start_s) begin
                    state_nxt_s = ST_MAC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (k_r == LAST_TAP_C) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_MAC;
                end
            end
            ST_OUT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Coefficient bank and write acknowledge; writes land only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= (i == 0) ? COEF_RST0_C : {COEF_WIDTH{1'b0}};
            end
            coef_ack_r <= 1'b0;
        end else begin
            coef_ack_r <= coef_wr_s;
            if (coef_wr_s) begin
                coef_r[coef_addr] <= coef_data;
            end
        end
    end

    // Delay line, write pointer, warm-up fill count and decimation phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
            dcnt_r   <= {DCNT_W{1'b0}};
        end else if (accept_s) begin
            dline_r[wr_ptr_r] <= sample_in;
            wr_ptr_r <= (wr_ptr_r == LAST_TAP_C) ? {PTR_W{1'b0}} : (wr_ptr_r + PTR_W'(1));
            if (!fill_full_s) begin
                fill_r <= fill_r + FILL_W'(1);
            end
            dcnt_r <= dec_hit_s ? {DCNT_W{1'b0}} : (dcnt_r + DCNT_W'(1));
        end
    end

    // MAC sequencer: clear on entry, then one product per cycle for TAPS cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            k_r      <= {PTR_W{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
        end else if (mac_start_s) begin
            // The sample being written this cycle is the newest one.
            rd_ptr_r <= wr_ptr_r;
            k_r      <= {PTR_W{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
        end else if (state_r == ST_MAC) begin
            acc_r    <= acc_sum_s;
            k_r      <= (k_r == LAST_TAP_C) ? {PTR_W{1'b0}} : (k_r + PTR_W'(1));
            rd_ptr_r <= (rd_ptr_r == {PTR_W{1'b0}}) ? LAST_TAP_C : (rd_ptr_r - PTR_W'(1));
        end
    end

    // Registered outputs; the result is captured off the final MAC sum so it appears during OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_ready_r <= 1'b1;
            out_r          <= {OUT_WIDTH{1'b0}};
            out_valid_r    <= 1'b0;
            out_sat_r      <= 1'b0;
        end else begin
            sample_ready_r <= (state_nxt_s == ST_IDLE);
            out_valid_r    <= emit_s;
            out_sat_r      <= emit_s && fmt_s[OUT_WIDTH];
            if (emit_s) begin
                out_r <= fmt_s[OUT_WIDTH-1:0];
            end
        end
    end

    assign sample_ready = sample_ready_r;
    assign coef_ack     = coef_ack_r;
    assign out          = out_r;
    assign out_valid    = out_valid_r;
    assign out_sat      = out_sat_r;

endmodule

// File: tb/tb_fir_tdm_decim.sv
// -----------------------------------------------------------------------------
// tb_fir_tdm_decim
//
// Drives two instances of fir_tdm_decim: u_dut (DECIM=1, full feature set) and
// u_dec (DECIM=4, default coefficients). Expected outputs come from a direct
// convolution over the accepted-sample history and are queued with the cycle
// at which they must appear; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_fir_tdm_decim;

    localparam int TAPS = 30;
    localparam int LAT  = TAPS + 1;

    typedef struct {
        logic signed [15:0] val;
        logic               sat;
        int                 cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               coef_ack;
    logic signed [15:0] out;
    logic               out_valid;
    logic               out_sat;

    logic signed [15:0] d_sample_in;
    logic               d_sample_valid;
    logic               d_sample_ready;
    logic               d_coef_we;
    logic [4:0]         d_coef_addr;
    logic signed [15:0] d_coef_data;
    logic               d_coef_ack;
    logic signed [15:0] d_out;
    logic               d_out_valid;
    logic               d_out_sat;

    exp_t   q_a[$];
    exp_t   q_b[$];
    longint coef_m [TAPS];
    longint hist[$];

    int checks     = 0;
    int failures   = 0;
    int ncyc       = 0;
    int acc_cyc    = 0;
    int d_cnt      = 0;
    int d_fill     = 0;
    int d_expected = 0;
    int d_pulses   = 0;

    always #5 clk = ~clk;

    fir_tdm_decim #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .DECIM(1), .OUT_WIDTH(16), .OUT_SHIFT(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ack(coef_ack),
        .out(out), .out_valid(out_valid), .out_sat(out_sat)
    );

    fir_tdm_decim #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS), .DECIM(4), .OUT_WIDTH(16), .OUT_SHIFT(8)
    ) u_dec (
        .clk(clk), .rst_n(rst_n),
        .sample_in(d_sample_in), .sample_valid(d_sample_valid), .sample_ready(d_sample_ready),
        .coef_we(d_coef_we), .coef_addr(d_coef_addr), .coef_data(d_coef_data), .coef_ack(d_coef_ack),
        .out(d_out), .out_valid(d_out_valid), .out_sat(d_out_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        q_a.delete();
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
        coef_m[0] = 256;
    endtask

    // Reference: y = (sum_k x[n-k]*c[k]) >>> 8, then clamp or wrap to 16 bits.
    function automatic exp_t model_out(input int cyc);
        exp_t   e;
        longint acc;
        longint sc;
        int     n;
        acc = 0;
        n = hist.size();
        for (int k = 0; k < TAPS; k++) acc += hist[n - 1 - k] * coef_m[k];
        sc = acc >>> 8;
`ifdef FIR_SAT_EN
        if (sc > 32767) begin
            e.val = 16'sh7fff; e.sat = 1'b1;
        end else if (sc < -32768) begin
            e.val = 16'sh8000; e.sat = 1'b1;
        end else begin
            e.val = sc[15:0]; e.sat = 1'b0;
        end
`else
        e.val = sc[15:0];
        e.sat = 1'b0;
`endif
        e.cyc = cyc;
        return e;
    endfunction

    // Offer one sample to u_dut (valid stays high afterwards); optional coefficient write in the accept cycle.
    task automatic send(input logic signed [15:0] v, input logic we, input logic [4:0] a, input logic signed [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        sample_in = v;
        sample_valid = 1'b1;
        while (sample_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_wait", 64'(n < 100), 64'sd1);
        coef_we = we; coef_addr = a; coef_data = d;
        @(posedge clk);
        if (we) coef_m[a] = d;
        acc_cyc = ncyc;
        hist.push_back(v);
        if (hist.size() >= TAPS) q_a.push_back(model_out(acc_cyc + LAT));
        if (we) begin
            @(negedge clk);
            coef_we = 1'b0;
            check("coef_ack_with_sample", coef_ack, 1);
        end
    endtask

    task automatic d_send(input logic signed [15:0] v);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        d_sample_in = v;
        d_sample_valid = 1'b1;
        while (d_sample_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_wait", 64'(n < 100), 64'sd1);
        @(posedge clk);
        d_cnt++;
        if (d_fill < TAPS) d_fill++;
        if ((d_cnt % 4) == 0 && d_fill == TAPS) begin
            e.val = v; e.sat = 1'b0; e.cyc = ncyc + LAT;
            q_b.push_back(e);
            d_expected++;
        end
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        @(negedge clk);
        sample_valid = 1'b0;
        while (sample_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_idle_wait", 64'(n < 100), 64'sd1);
    endtask

    task automatic wr_coef(input logic [4:0] a, input logic signed [15:0] d, input logic exp_ack);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_ack", coef_ack, exp_ack);
        if (exp_ack) coef_m[a] = d;
    endtask

    // Cycle counter plus output monitors: out_valid must match the scoreboard timing every cycle.
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        ncyc++;
        ev = (q_a.size() > 0) && (q_a[0].cyc == ncyc);
        check("a_out_valid", out_valid, ev);
        if (ev) begin
            e = q_a.pop_front();
            check("a_out", out, e.val);
            check("a_out_sat", out_sat, e.sat);
        end
        ev = (q_b.size() > 0) && (q_b[0].cyc == ncyc);
        check("b_out_valid", d_out_valid, ev);
        if (ev) begin
            e = q_b.pop_front();
            check("b_out", d_out, e.val);
        end
        if (d_out_valid === 1'b1) d_pulses++;
    end

    initial begin
        int prev;
        int n;
        sample_in = '0; sample_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        d_sample_in = '0; d_sample_valid = 1'b0;
        d_coef_we = 1'b0; d_coef_addr = '0; d_coef_data = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_coef_ack", coef_ack, 0);
        check("rst_ready", sample_ready, 1);
        rst_n = 1'b1;

        // Impulse default: only the 30th sample yields an output, equal to the input.
        for (int i = 0; i < 30; i++) send(16'sd100, 1'b0, 5'd0, 16'sd0);
        go_idle();

        // Out-of-range address is ignored; then load full-scale coefficients.
        wr_coef(5'd31, 16'sd77, 1'b0);
        for (int k = 0; k < TAPS; k++) wr_coef(5'(k), 16'sd32767, 1'b1);
        for (int i = 0; i < 20; i++) send(16'sd32767, 1'b0, 5'd0, 16'sd0);
        for (int i = 0; i < 10; i++) send(16'sh8000, 1'b0, 5'd0, 16'sd0);
        go_idle();

        // Tap order with a held sample_valid; also a write attempted during MAC.
        for (int k = 0; k < TAPS; k++) wr_coef(5'(k), (k == 1) ? 16'sd256 : 16'sd0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            prev = acc_cyc;
            send(16'(i), 1'b0, 5'd0, 16'sd0);
            if (i > 1) check("accept_spacing", acc_cyc - prev, TAPS + 2);
            if (i == 5) wr_coef(5'd5, 16'sd999, 1'b0);
        end
        // Coefficient write and sample accept in the same cycle: new tap is used immediately.
        send(16'sd50, 1'b1, 5'd1, 16'sd512);
        go_idle();

        // Reset in the middle of a MAC pass.
        send(16'sd7, 1'b0, 5'd0, 16'sd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_out", out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ready", sample_ready, 1);
        check("midrst_coef_ack", coef_ack, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 32; i++) send(16'(i * 37 - 500), 1'b0, 5'd0, 16'sd0);
        go_idle();

        // Decimation by 4 on the second instance.
        for (int i = 1; i <= 120; i++) d_send(16'(i * 11 - 600));
        @(negedge clk);
        d_sample_valid = 1'b0;

        n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        check("b_pulse_count", d_pulses, d_expected);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
